dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 (pipeline MEM stage) and port 1 (debug/bridge load-store port).
- Per request it performs:
  - round-robin arbitration;
  - alignment checking;
  - byte-lane steering and load extension;
  - a multi-cycle req/ready handshake with the memory.
- Sits between the MEM-stage stall logic and the DM macro.

Parameters:
- AW, 32, byte-address width.
- TIMEOUT, 255, max cycles waiting for mem_ready; only used with DM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_we  in  2  per-port store (1) / load (0).
- req_op  in  2x3  per-port width op: W=0, H=1, HU=2, B=3, BU=4; other codes illegal.
- req_addr  in  2xAW  per-port byte address.
- req_wdata  in  2x32  per-port store data, right-aligned.
- req_ready  out  2  one-hot acceptance pulse.
- rsp_valid  out  2  one-hot, 1-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal op, or timeout; qualified by rsp_valid.
- mem_en  out  1  memory request strobe.
- mem_addr  out  AW  word address, low 2 bits forced 0.
- mem_byteen  out  4  byte write enables; 0000 on loads.
- mem_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  raw word read.
- mem_ready  in  1  memory completes current access this cycle.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - round-robin pointer = port 0.
- States:
  - IDLE: wait for any req_valid.
  - GRANT: latch the winning request.
  - ACCESS: mem_en high.
  - RESP: pulse response.
- IDLE -> GRANT when any req_valid=1:
  - winner = the pointer port if it is valid, else the other port;
  - req_ready[winner] pulses for 1 cycle;
  - op, we, addr and wdata are registered.
- Requesters hold their fields while valid; after req_ready they may drop or change them.
- GRANT checks the latched request:
  - illegal op, W with addr[1:0]!=0, or H/HU with addr[0]!=0 -> RESP with err=1, with no memory access;
  - otherwise -> ACCESS.
- ACCESS:
  - mem_en=1, with mem_addr, mem_byteen and mem_wdata stable until mem_ready;
  - on mem_ready -> RESP, capturing the extracted load data;
  - a mem_ready seen in the first ACCESS cycle is legal.
- Store lane rules:
  - W: byteen=1111.
  - H: addr[1]=0 -> 0011, data in [15:0]; addr[1]=1 -> 1100, data in [31:16].
  - B: byteen = 0001 shifted left by addr[1:0]; data byte replicated to that lane, other lanes 0.
- Load extraction:
  - H and B sign-extend; HU and BU zero-extend;
  - selected lane is addr[1] for halves, addr[1:0] for bytes.
- RESP:
  - rsp_valid[granted]=1 for exactly 1 cycle;
  - rsp_err and rsp_rdata valid that cycle;
  - pointer flips to the non-granted port;
  - -> IDLE.
- Latency:
  - accept to response = 3 cycles + mem wait;
  - error path = 2 cycles.
- Both ports valid in the same cycle: the pointer port wins; the loser keeps valid and wins next arbitration, so there is no starvation.
- mem_ready outside ACCESS is ignored.
- reset mid-access aborts immediately: mem_en drops asynchronously and no rsp is issued.

Optional Feature:
- Macro: DM_TIMEOUT_EN.
- Defined:
  - a counter runs in ACCESS;
  - if mem_ready is still absent after TIMEOUT cycles -> RESP with rsp_err=1, rdata=0, mem_en dropped;
  - a mem_ready arriving in the same cycle as expiry wins (normal response).
- Undefined: ACCESS waits indefinitely; no counter is synthesized.

Decomposition:
- Shared package/header: op encodings (W/H/HU/B/BU), state encodings, byteen constants.
- Sub-module dm_lane_align, combinational:
  - inputs addr[1:0], op, we, wdata, rdata;
  - outputs byteen, steered wdata, extended rdata, misalign flag.
- FSM, arbitration and timeout live in the top module.

Test Plan:
- Port0 SB, addr 0x1003, wdata 0xAB -> mem_addr 0x1000, byteen 1000, mem_wdata 0xAB000000; rsp_valid[0], err=0.
- Port1 LH, addr 0x2002, mem_rdata 0x8001_1234 -> rsp_rdata 0xFFFF8001; LHU same -> 0x00008001.
- Both ports valid continuously with 4 loads each, mem_ready immediate -> grants strictly alternate 0,1,0,1…, starting with port 0 after reset.
- Port0 LW, addr 0x0006 -> no mem_en, rsp_err=1 two cycles after req_ready; op code 7 -> same.
- mem_ready delayed 5 cycles -> mem_* outputs stable throughout; rsp 1 cycle after ready. With DM_TIMEOUT_EN and TIMEOUT=4, no ready -> err=1, mem_en low after the timeout.
- reset asserted in ACCESS -> mem_en=0 and all outputs 0 immediately; no rsp_valid after release; pointer back to port 0.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: width ops, FSM states, byte-enable patterns.
package dm_port_arbiter_pkg;

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_B  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_BU);
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester and memory-side signals of the data-memory port arbiter.
interface dm_port_arbiter_if #(
  parameter int AW = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_we;
  logic [1:0][2:0]    req_op;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][31:0]   req_wdata;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               mem_en;
  logic [AW-1:0]      mem_addr;
  logic [3:0]         mem_byteen;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic               mem_ready;

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_addr, mem_byteen, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_addr, mem_byteen, mem_wdata
  );
endinterface

// File: rtl/dm_port_arbiter_lane_align.sv
// dm_lane_align: combinational byte-lane steering for stores and lane extraction/extension for loads.
module dm_lane_align
  import dm_port_arbiter_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  op_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [4:0]  sh;
  logic [15:0] half_l;
  logic [7:0]  byte_l;

  assign sh     = {addr_i, 3'b000};
  assign half_l = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign byte_l = rdata_i[sh +: 8];

  always_comb begin
    byteen_o   = BE_NONE;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    case (op_i)
      OP_W: begin
        misalign_o = |addr_i;
        rdata_o    = rdata_i;
        if (we_i) begin
          byteen_o = BE_WORD;
          wdata_o  = wdata_i;
        end
      end
      OP_H, OP_HU: begin
        misalign_o = addr_i[0];
        rdata_o    = {{16{(op_i == OP_H) & half_l[15]}}, half_l};
        if (we_i) begin
          byteen_o = addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
          wdata_o  = addr_i[1] ? {wdata_i[15:0], 16'h0000} : {16'h0000, wdata_i[15:0]};
        end
      end
      OP_B, OP_BU: begin
        rdata_o = {{24{(op_i == OP_B) & byte_l[7]}}, byte_l};
        if (we_i) begin
          byteen_o = BE_BYTE0 << addr_i;
          wdata_o  = {24'h000000, wdata_i[7:0]} << sh;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of the data memory; DM_TIMEOUT_EN adds an ACCESS watchdog.
//   state  | meaning
//   IDLE   | wait for any req_valid, pulse req_ready to the winner
//   GRANT  | check latched request (legal op, alignment)
//   ACCESS | mem_en high until mem_ready (or timeout)
//   RESP   | one-cycle rsp_valid, flip round-robin pointer
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  dm_port_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic [2:0]    op_q, op_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          winner;
  logic [1:0]    ready_c;
  logic          access_c;
  logic          resp_c;
  logic          timeout_c;
  logic [3:0]    be_c;
  logic [31:0]   wd_c;
  logic [31:0]   rd_c;
  logic          misalign_c;

  dm_lane_align u_lane (
    .addr_i     (addr_q[1:0]),
    .op_i       (op_q),
    .we_i       (we_q),
    .wdata_i    (wdata_q),
    .rdata_i    (bus.mem_rdata),
    .byteen_o   (be_c),
    .wdata_o    (wd_c),
    .rdata_o    (rd_c),
    .misalign_o (misalign_c)
  );

`ifdef DM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Loaded in GRANT so the last ACCESS cycle is the one where the count reads zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_GRANT) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (state_q == ST_ACCESS && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout_c = (state_q == ST_ACCESS) && (cnt_q == '0);
`else
  assign timeout_c = 1'b0;
`endif

  assign winner = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready_c = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          state_d         = ST_GRANT;
          gnt_d           = winner;
          op_d            = bus.req_op[winner];
          we_d            = bus.req_we[winner];
          addr_d          = bus.req_addr[winner];
          wdata_d         = bus.req_wdata[winner];
          ready_c[winner] = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!op_legal(op_q) || misalign_c) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A ready coinciding with timeout expiry completes normally.
        if (bus.mem_ready) begin
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : rd_c;
          state_d = ST_RESP;
        end else if (timeout_c) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_d   = ~gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign access_c = (state_q == ST_ACCESS);
  assign resp_c   = (state_q == ST_RESP);

  // IDLE holds during reset, so the acceptance pulse is masked until reset releases.
  assign bus.req_ready  = rst_n ? ready_c : 2'b00;
  assign bus.mem_en     = access_c;
  assign bus.mem_addr   = access_c ? {addr_q[AW-1:2], 2'b00} : '0;
  assign bus.mem_byteen = access_c ? be_c : BE_NONE;
  assign bus.mem_wdata  = access_c ? wd_c : '0;
  assign bus.rsp_valid  = resp_c ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_err    = resp_c & err_q;
  assign bus.rsp_rdata  = resp_c ? rdata_q : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter; define DM_TIMEOUT_EN to also exercise the watchdog.
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

`ifdef DM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam int WAIT_N     = 3;
`else
  localparam int TB_TIMEOUT = 255;
  localparam int WAIT_N     = 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dm_port_arbiter_if #(.AW(32)) bus ();

  dm_port_arbiter #(.AW(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          accepted;
    int          rdy_cyc;
    logic [1:0]  rdy_vec;
    int          en_cnt;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    bit          stable;
    bit          got_rsp;
    int          rsp_cyc;
    logic [1:0]  rsp_v;
    logic        rsp_e;
    logic [31:0] rsp_d;
    logic        en_at_rsp;
  } txn_res_t;

  // Reference: access size from the op, legality from size/offset, lanes by arithmetic shifts.
  function automatic void model(input bit we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output bit err, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] rd);
    int size;
    int off;
    longint mask;
    longint v;
    off = int'(addr % 4);
    case (op)
      3'd0:       size = 4;
      3'd1, 3'd2: size = 2;
      3'd3, 3'd4: size = 1;
      default:    size = 0;
    endcase
    if (size == 0) err = 1'b1;
    else           err = (off % size) != 0;
    be = '0; wd = '0; rd = '0;
    if (!err) begin
      mask = (longint'(1) << (8 * size)) - 1;
      if (we) begin
        be = 4'(((1 << size) - 1) << off);
        wd = 32'((longint'(wdata) & mask) << (8 * off));
      end else begin
        v = (longint'(rdata) >> (8 * off)) & mask;
        if ((op == 3'd1 || op == 3'd3) && v > (mask >> 1)) v = v - (mask + 1);
        rd = 32'(v);
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_we = '0; bus.req_op = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request on port p; memory answers after `delay` extra ACCESS cycles, stray mem_ready elsewhere.
  task automatic run_txn(input logic p, input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                         output txn_res_t r);
    r = '{default: 0};
    r.stable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.req_valid    = '0;
      bus.req_valid[p] = !r.accepted;
      if (!r.accepted) begin
        bus.req_we[p] = we; bus.req_op[p] = op; bus.req_addr[p] = addr; bus.req_wdata[p] = wdata;
      end
      #1;
      if (!r.accepted && bus.req_ready != 2'b00) begin
        r.accepted = 1'b1; r.rdy_cyc = k; r.rdy_vec = bus.req_ready;
      end
      if (bus.mem_en) begin
        if (r.en_cnt == 0) begin
          r.m_addr = bus.mem_addr; r.m_be = bus.mem_byteen; r.m_wd = bus.mem_wdata;
        end else if (bus.mem_addr !== r.m_addr || bus.mem_byteen !== r.m_be || bus.mem_wdata !== r.m_wd) begin
          r.stable = 1'b0;
        end
        r.en_cnt++;
        bus.mem_ready = (r.en_cnt > delay);
        bus.mem_rdata = bus.mem_ready ? rdata : $urandom();
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom();
      end
      if (bus.rsp_valid != 2'b00) begin
        r.got_rsp = 1'b1; r.rsp_cyc = k; r.rsp_v = bus.rsp_valid;
        r.rsp_e = bus.rsp_err; r.rsp_d = bus.rsp_rdata; r.en_at_rsp = bus.mem_en;
        break;
      end
    end
    bus.mem_ready = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.req_valid = 2'b11; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.mem_en} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.rsp_valid, bus.rsp_err, bus.mem_en}); end
    checks++; if ({bus.rsp_rdata, bus.mem_addr, bus.mem_byteen, bus.mem_wdata} !== 100'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {bus.rsp_rdata, bus.mem_addr, bus.mem_byteen, bus.mem_wdata}); end
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if ({bus.mem_en, bus.rsp_valid, bus.req_ready} !== 5'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 00000", {bus.mem_en, bus.rsp_valid, bus.req_ready}); end
  endtask

  task automatic test_store_byte();
    txn_res_t r;
    run_txn(1'b0, 1'b1, OP_B, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, r);
    checks++; if (r.m_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h expected 00001000", r.m_addr); end
    checks++; if (r.m_be !== 4'b1000) begin errors++; $display("FAIL sb_byteen: got %b expected 1000", r.m_be); end
    checks++; if (r.m_wd !== 32'hAB00_0000) begin errors++; $display("FAIL sb_wdata: got %h expected ab000000", r.m_wd); end
    checks++; if ({r.got_rsp, r.rsp_v, r.rsp_e} !== 4'b1010) begin errors++; $display("FAIL sb_rsp: got %b expected 1010", {r.got_rsp, r.rsp_v, r.rsp_e}); end
  endtask

  task automatic test_load_half();
    txn_res_t r;
    run_txn(1'b1, 1'b0, OP_H, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, r);
    checks++; if ({r.rsp_v, r.rsp_e} !== 3'b100) begin errors++; $display("FAIL lh_rsp: got %b expected 100", {r.rsp_v, r.rsp_e}); end
    checks++; if (r.rsp_d !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata: got %h expected ffff8001", r.rsp_d); end
    checks++; if (r.m_be !== 4'b0000) begin errors++; $display("FAIL lh_byteen: got %b expected 0000", r.m_be); end
    run_txn(1'b1, 1'b0, OP_HU, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, r);
    checks++; if (r.rsp_d !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata: got %h expected 00008001", r.rsp_d); end
  endtask

  task automatic test_errors();
    txn_res_t r;
    run_txn(1'b0, 1'b0, OP_W, 32'h0000_0006, 32'h0, 32'h1111_2222, 0, r);
    checks++; if ({r.got_rsp, r.rsp_v, r.rsp_e} !== 4'b1011) begin errors++; $display("FAIL lw_mis_rsp: got %b expected 1011", {r.got_rsp, r.rsp_v, r.rsp_e}); end
    checks++; if (r.en_cnt !== 0) begin errors++; $display("FAIL lw_mis_mem_en: got %0d cycles expected 0", r.en_cnt); end
    checks++; if (r.rsp_cyc - r.rdy_cyc !== 2) begin errors++; $display("FAIL lw_mis_latency: got %0d expected 2", r.rsp_cyc - r.rdy_cyc); end
    checks++; if (r.rsp_d !== 32'h0) begin errors++; $display("FAIL lw_mis_rdata: got %h expected 0", r.rsp_d); end
    run_txn(1'b0, 1'b1, 3'd7, 32'h0000_0000, 32'h5555_5555, 32'h0, 0, r);
    checks++; if ({r.got_rsp, r.rsp_e, r.en_cnt} !== {2'b11, 32'd0}) begin errors++; $display("FAIL op7: got rsp=%b err=%b en=%0d expected 1 1 0", r.got_rsp, r.rsp_e, r.en_cnt); end
    checks++; if (r.rsp_cyc - r.rdy_cyc !== 2) begin errors++; $display("FAIL op7_latency: got %0d expected 2", r.rsp_cyc - r.rdy_cyc); end
  endtask

  task automatic test_mem_wait();
    txn_res_t r;
    logic [31:0] wd;
    wd = $urandom();
    run_txn(1'b0, 1'b1, OP_W, 32'h0000_0040, wd, 32'h0, WAIT_N, r);
    checks++; if (!r.stable) begin errors++; $display("FAIL wait_stable: mem_* changed during ACCESS"); end
    checks++; if (r.en_cnt !== WAIT_N + 1) begin errors++; $display("FAIL wait_en_cycles: got %0d expected %0d", r.en_cnt, WAIT_N + 1); end
    checks++; if (r.rsp_cyc - r.rdy_cyc !== 3 + WAIT_N) begin errors++; $display("FAIL wait_latency: got %0d expected %0d", r.rsp_cyc - r.rdy_cyc, 3 + WAIT_N); end
    checks++; if ({r.m_addr, r.m_be, r.m_wd} !== {32'h40, 4'hF, wd}) begin errors++; $display("FAIL wait_fields: got %h/%b/%h expected 40/1111/%h", r.m_addr, r.m_be, r.m_wd, wd); end
  endtask

  task automatic test_alternation();
    int rem [2];
    int order[$];
    int rsp_order[$];
    bit onehot_ok;
    reset_dut();
    rem[0] = 4; rem[1] = 4; onehot_ok = 1'b1;
    for (int k = 0; k < 200 && rsp_order.size() < 8; k++) begin
      @(negedge clk);
      bus.req_valid[0] = rem[0] > 0; bus.req_valid[1] = rem[1] > 0;
      bus.req_we = 2'b00; bus.req_op[0] = OP_W; bus.req_op[1] = OP_W;
      bus.req_addr[0] = 32'h100 + 32'(4 * rem[0]); bus.req_addr[1] = 32'h200 + 32'(4 * rem[1]);
      #1;
      if (bus.req_ready == 2'b11) onehot_ok = 1'b0;
      if (bus.req_ready[0]) begin order.push_back(0); rem[0]--; end
      if (bus.req_ready[1]) begin order.push_back(1); rem[1]--; end
      bus.mem_ready = bus.mem_en;
      bus.mem_rdata = $urandom();
      if (bus.rsp_valid[0]) rsp_order.push_back(0);
      if (bus.rsp_valid[1]) rsp_order.push_back(1);
    end
    idle_inputs();
    checks++; if (!onehot_ok) begin errors++; $display("FAIL alt_onehot: req_ready had both bits set"); end
    checks++; if (rsp_order.size() !== 8) begin errors++; $display("FAIL alt_count: got %0d responses expected 8", rsp_order.size()); end
    for (int j = 0; j < order.size() && j < 8; j++) begin
      checks++; if (order[j] !== j % 2) begin errors++; $display("FAIL alt_grant[%0d]: got port %0d expected %0d", j, order[j], j % 2); end
    end
    for (int j = 0; j < rsp_order.size() && j < 8; j++) begin
      checks++; if (rsp_order[j] !== j % 2) begin errors++; $display("FAIL alt_rsp[%0d]: got port %0d expected %0d", j, rsp_order[j], j % 2); end
    end
  endtask

  task automatic test_random();
    txn_res_t r;
    logic p; bit we; logic [2:0] op; logic [31:0] addr, wd, rd;
    int delay; bit e_err; logic [3:0] e_be; logic [31:0] e_wd, e_rd;
    for (int n = 0; n < 24; n++) begin
      p = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
      addr = $urandom(); wd = $urandom(); rd = $urandom(); delay = int'($urandom_range(0, 3));
      model(we, op, addr, wd, rd, e_err, e_be, e_wd, e_rd);
      run_txn(p, we, op, addr, wd, rd, delay, r);
      checks++; if (!r.got_rsp) begin errors++; $display("FAIL rnd%0d_rsp: no response within budget", n); continue; end
      checks++; if (r.rdy_vec !== (2'b01 << p)) begin errors++; $display("FAIL rnd%0d_ready: got %b expected port %0d", n, r.rdy_vec, p); end
      checks++; if (r.rsp_v !== (2'b01 << p)) begin errors++; $display("FAIL rnd%0d_rsp_valid: got %b expected port %0d", n, r.rsp_v, p); end
      checks++; if (r.rsp_e !== e_err) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b (op %0d addr %h)", n, r.rsp_e, e_err, op, addr); end
      checks++; if (r.rsp_d !== e_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h (op %0d addr %h)", n, r.rsp_d, e_rd, op, addr); end
      checks++; if (r.rsp_cyc - r.rdy_cyc !== (e_err ? 2 : 3 + delay)) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, r.rsp_cyc - r.rdy_cyc, e_err ? 2 : 3 + delay); end
      checks++; if ((r.en_cnt != 0) !== !e_err) begin errors++; $display("FAIL rnd%0d_mem_en: got %0d cycles, err expected %b", n, r.en_cnt, e_err); end
      if (!e_err) begin
        checks++; if (r.m_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL rnd%0d_addr: got %h expected %h", n, r.m_addr, {addr[31:2], 2'b00}); end
        checks++; if (r.m_be !== e_be) begin errors++; $display("FAIL rnd%0d_byteen: got %b expected %b", n, r.m_be, e_be); end
        checks++; if (we && r.m_wd !== e_wd) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, r.m_wd, e_wd); end
        checks++; if (!r.stable) begin errors++; $display("FAIL rnd%0d_stable: mem_* changed during ACCESS", n); end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    txn_res_t r;
    bit seen_en, seen_rsp;
    reset_dut();
    run_txn(1'b0, 1'b0, OP_W, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, r);
    seen_en = 1'b0;
    for (int k = 0; k < 20 && !seen_en; k++) begin
      @(negedge clk);
      bus.req_valid = (k == 0) ? 2'b01 : 2'b00;
      bus.req_we[0] = 1'b0; bus.req_op[0] = OP_W; bus.req_addr[0] = 32'h20;
      bus.mem_ready = 1'b0;
      #1; seen_en = bus.mem_en;
    end
    checks++; if (!seen_en) begin errors++; $display("FAIL abort_reach_access: mem_en never rose"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL abort_mem_en: got %b expected 0", bus.mem_en); end
    checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_addr, bus.mem_byteen, bus.mem_wdata} !== 105'h0) begin errors++; $display("FAIL abort_outputs: nonzero output during reset"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_rsp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      if (bus.rsp_valid != 2'b00 || bus.mem_en) seen_rsp = 1'b1;
    end
    bus.mem_ready = 1'b0;
    checks++; if (seen_rsp) begin errors++; $display("FAIL abort_no_rsp: response or access after reset release"); end
    @(negedge clk);
    bus.req_valid = 2'b11; bus.req_op[1] = OP_W; bus.req_addr[1] = 32'h30; bus.req_we[1] = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL abort_ptr: got ready %b expected 01", bus.req_ready); end
    reset_dut();
  endtask

`ifdef DM_TIMEOUT_EN
  task automatic test_timeout();
    txn_res_t r;
    run_txn(1'b0, 1'b0, OP_W, 32'h0000_0080, 32'h0, 32'hDEAD_BEEF, 1000, r);
    checks++; if ({r.got_rsp, r.rsp_e} !== 2'b11) begin errors++; $display("FAIL to_err: got rsp=%b err=%b expected 1 1", r.got_rsp, r.rsp_e); end
    checks++; if (r.rsp_d !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h expected 0", r.rsp_d); end
    checks++; if (r.en_cnt !== TB_TIMEOUT) begin errors++; $display("FAIL to_cycles: got %0d expected %0d", r.en_cnt, TB_TIMEOUT); end
    checks++; if (r.en_at_rsp !== 1'b0) begin errors++; $display("FAIL to_mem_en: got %b expected 0", r.en_at_rsp); end
    run_txn(1'b1, 1'b0, OP_W, 32'h0000_0084, 32'h0, 32'hCAFE_0001, TB_TIMEOUT - 1, r);
    checks++; if ({r.rsp_e, r.rsp_d} !== {1'b0, 32'hCAFE_0001}) begin errors++; $display("FAIL to_ready_wins: got err=%b rdata=%h expected 0 cafe0001", r.rsp_e, r.rsp_d); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_errors();
    test_mem_wait();
    test_alternation();
    test_random();
    test_reset_mid_access();
`ifdef DM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
